// File: rtl/mem_access_pkg.sv
// Shared constants and state type for the memory access sequencer.
// Holds the state encoding and the default bus widths.
package mem_access_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUS  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int DEF_BITS_DATA = 32;
    localparam int DEF_BITS_ADDR = 16;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        BUS  = ST_BUS,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/mem_data_latch.sv
// Response data register with load enable and synchronous clear.
// Holds the word returned on rsp_rdata.
module mem_data_latch
    import mem_access_pkg::*;
#(
    parameter int BITS_DATA = DEF_BITS_DATA
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load,
    input  logic [BITS_DATA-1:0] d,
    output logic [BITS_DATA-1:0] q
);

    // Clear wins over load so reset always leaves the register at zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Load/store sequencer between a CPU request channel and an enable/ack bus.
// Optional bus timeout is compiled in with `define MEM_TIMEOUT_EN.
module mem_access_sequencer
    import mem_access_pkg::*;
#(
    parameter int BITS_DATA      = DEF_BITS_DATA,
    parameter int BITS_ADDR      = DEF_BITS_ADDR,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [BITS_ADDR-1:0] req_addr,
    input  logic [BITS_DATA-1:0] req_wdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [BITS_ADDR-1:0] mem_addr,
    output logic [BITS_DATA-1:0] mem_wdata,
    input  logic [BITS_DATA-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BITS_DATA-1:0] rsp_rdata,
    output logic                 rsp_err
);

    // The wait counter is 8 bits wide, so the limit must fit in it.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be in 1..255");
    end

    state_t               state;
    state_t               state_nx;
    logic                 accept;
    logic                 ack_hit;
    logic                 tmo_hit;
    logic                 lat_we;
    logic [BITS_ADDR-1:0] lat_addr;
    logic [BITS_DATA-1:0] lat_wdata;
    logic [BITS_DATA-1:0] load_val;

    assign ack_hit  = (state == BUS) && mem_ack;
    // Stores complete with a zero data word; so do timed-out accesses.
    assign load_val = (ack_hit && !lat_we) ? mem_rdata : '0;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       err_q;

    // An ack in the final allowed cycle takes priority over the timeout.
    assign tmo_hit = (state == BUS) && !mem_ack
                  && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign rsp_err = err_q;

    // Count BUS cycles that ended without an ack.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            wait_cnt <= '0;
        end else if ((state == BUS) && !mem_ack) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Error flag is raised by a timeout and dropped on leaving RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (tmo_hit) begin
            err_q <= 1'b1;
        end else if ((state == RESP) && rsp_ready) begin
            err_q <= 1'b0;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign rsp_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake/bus strobes.
    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) state_nx = BUS;
            end
            BUS: begin
                mem_en = 1'b1;
                if (ack_hit || tmo_hit) state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        mem_we = mem_en && lat_we;
    end

    // Request fields are captured once and held for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;

    mem_data_latch #(
        .BITS_DATA (BITS_DATA)
    ) u_data (
        .clk  (clk),
        .clr  (reset),
        .load (ack_hit || tmo_hit),
        .d    (load_val),
        .q    (rsp_rdata)
    );

endmodule
